// File: rtl/pc_seq_ctrl_if.sv
// ---------------------------------------------------------------------------
// pc_seq_ctrl_if
// Groups the pipeline-facing signals of the PC sequencer.
//   master : pipeline side (drives EX/ID/hazard inputs, observes PC outputs)
//   slave  : the sequencer itself
// Signals:
//   ex_valid, branch_f[1:0], pc_branch[31:0], alu_result[31:0]  redirect request
//   stall, halt_req, resume                                     flow control
//   pc[31:0], fetch_en, flush, halted, misalign_err             sequencer state
//   redirect_cnt[CNT_W-1:0]                                     accepted redirects
// ---------------------------------------------------------------------------
interface pc_seq_ctrl_if #(
    parameter int CNT_W = 16
);
    logic              ex_valid;
    logic [1:0]        branch_f;
    logic [31:0]       pc_branch;
    logic [31:0]       alu_result;
    logic              stall;
    logic              halt_req;
    logic              resume;
    logic [31:0]       pc;
    logic              fetch_en;
    logic              flush;
    logic              halted;
    logic              misalign_err;
    logic [CNT_W-1:0]  redirect_cnt;

    modport master (
        output ex_valid, branch_f, pc_branch, alu_result, stall, halt_req, resume,
        input  pc, fetch_en, flush, halted, misalign_err, redirect_cnt
    );

    modport slave (
        input  ex_valid, branch_f, pc_branch, alu_result, stall, halt_req, resume,
        output pc, fetch_en, flush, halted, misalign_err, redirect_cnt
    );
endinterface

// File: rtl/pc_seq_ctrl.sv
// ---------------------------------------------------------------------------
// pc_seq_ctrl
// Program-counter sequencer with RUN / HALT / TRAP control.
// Ports:
//   clk  : clock, all state updates on the rising edge
//   rst  : asynchronous active-low reset
//   bus  : pc_seq_ctrl_if.slave (redirect/stall/halt inputs, pc/fetch outputs)
// Behaviour summary:
//   RUN  : next pc priority is redirect > stall > halt_req > pc+4.
//          A misaligned redirect target traps without moving the pc.
//   HALT / TRAP : pc frozen, fetch disabled, only resume is honoured.
// ---------------------------------------------------------------------------
module pc_seq_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 16
) (
    input  logic            clk,
    input  logic            rst,
    pc_seq_ctrl_if.slave    bus
);
    localparam logic [1:0] ST_RUN  = 2'd0;
    localparam logic [1:0] ST_HALT = 2'd1;
    localparam logic [1:0] ST_TRAP = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [31:0]      pc_q, pc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             in_run;
    logic             redirect;
    logic [31:0]      target;
    logic             target_misaligned;

    // Unused encoding 2'd3 is treated as RUN so the FSM can never lock up.
    assign in_run            = (state_q != ST_HALT) && (state_q != ST_TRAP);
    assign redirect          = in_run && bus.ex_valid &&
                               ((bus.branch_f == 2'b10) || (bus.branch_f == 2'b01));
    assign target            = (bus.branch_f == 2'b10) ? bus.pc_branch : bus.alu_result;
    assign target_misaligned = (target[1:0] != 2'b00);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        if (in_run) begin
            state_d = ST_RUN;
            if (redirect) begin
                if (target_misaligned) begin
                    // Trap wins over a simultaneous halt request.
                    state_d = ST_TRAP;
                end else begin
                    pc_d  = target;
                    cnt_d = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
                    // Halt lands on the target so resume restarts there.
                    if (bus.halt_req) begin
                        state_d = ST_HALT;
                    end
                end
            end else if (bus.stall) begin
                pc_d = pc_q;
            end else if (bus.halt_req) begin
                state_d = ST_HALT;
            end else begin
                pc_d = pc_q + 32'd4;
            end
        end else if (bus.resume) begin
            state_d = ST_RUN;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_RUN;
            pc_q    <= RESET_PC;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
        end
    end

    // Gated with rst because reset forces RUN, yet nothing may fetch or
    // flush while reset is held.
    assign bus.fetch_en     = rst && in_run;
    assign bus.flush        = rst && redirect;
    assign bus.pc           = pc_q;
    assign bus.halted       = (state_q == ST_HALT);
    assign bus.misalign_err = (state_q == ST_TRAP);
    assign bus.redirect_cnt = cnt_q;
endmodule

// File: tb/tb_pc_seq_ctrl.sv
module tb_pc_seq_ctrl;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          CNT_W    = 4;
    localparam int          CNT_MAX  = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pc_seq_ctrl_if #(.CNT_W(CNT_W)) bus();

    pc_seq_ctrl #(.RESET_PC(RESET_PC), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: architectural view only (pc, counter, two mode flags).
    logic [31:0] m_pc;
    int          m_cnt;
    bit          m_halted;
    bit          m_trapped;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_pc      = RESET_PC;
        m_cnt     = 0;
        m_halted  = 1'b0;
        m_trapped = 1'b0;
    endtask

    task automatic drive(input bit ev, input logic [1:0] bf, input logic [31:0] pb,
                         input logic [31:0] alu, input bit st, input bit hr, input bit res);
        bus.ex_valid   = ev;
        bus.branch_f   = bf;
        bus.pc_branch  = pb;
        bus.alu_result = alu;
        bus.stall      = st;
        bus.halt_req   = hr;
        bus.resume     = res;
    endtask

    // Compare every output against the model given the inputs now applied.
    task automatic check_outputs(input string ctx);
        bit running;
        bit jump;
        running = !m_halted && !m_trapped;
        jump    = running && bus.ex_valid && (bus.branch_f == 2'b10 || bus.branch_f == 2'b01);
        check({ctx, ".pc"},       bus.pc,                   m_pc);
        check({ctx, ".fetch_en"}, {31'd0, bus.fetch_en},    {31'd0, running});
        check({ctx, ".flush"},    {31'd0, bus.flush},       {31'd0, jump});
        check({ctx, ".halted"},   {31'd0, bus.halted},      {31'd0, m_halted});
        check({ctx, ".misalign"}, {31'd0, bus.misalign_err}, {31'd0, m_trapped});
        check({ctx, ".cnt"},      32'(bus.redirect_cnt),    32'(m_cnt));
    endtask

    // One clock of stimulus: drive at negedge, check, then advance the model at posedge.
    task automatic step(input string ctx, input bit ev, input logic [1:0] bf, input logic [31:0] pb,
                        input logic [31:0] alu, input bit st, input bit hr, input bit res);
        logic [31:0] tgt;
        @(negedge clk);
        drive(ev, bf, pb, alu, st, hr, res);
        #1;
        check_outputs(ctx);
        $display("%-10s ev=%0d bf=%b st=%0d hr=%0d res=%0d | pc=%h fe=%0d fl=%0d h=%0d t=%0d cnt=%0d",
                 ctx, ev, bf, st, hr, res, bus.pc, bus.fetch_en, bus.flush,
                 bus.halted, bus.misalign_err, bus.redirect_cnt);
        @(posedge clk);
        tgt = (bf == 2'b10) ? pb : alu;
        if (m_halted || m_trapped) begin
            if (res) begin
                m_halted  = 1'b0;
                m_trapped = 1'b0;
            end
        end else if (ev && (bf == 2'b10 || bf == 2'b01)) begin
            if (tgt % 4 == 0) begin
                m_pc = tgt;
                if (m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
                if (hr) m_halted = 1'b1;
            end else begin
                m_trapped = 1'b1;
            end
        end else if (!st) begin
            if (hr) m_halted = 1'b1;
            else    m_pc = m_pc + 32'd4;
        end
    endtask

    task automatic idle(input string ctx);
        step(ctx, 1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        logic [31:0] pb;
        logic [31:0] alu;

        // Reset held from time 0 with a redirect pending: nothing may fetch or flush.
        rst = 1'b0;
        drive(1'b1, 2'b10, 32'h40, 32'h0, 1'b0, 1'b0, 1'b0);
        model_reset();
        #2;
        check("rst.pc",    bus.pc, RESET_PC);
        check("rst.cnt",   32'(bus.redirect_cnt), 32'h0);
        check("rst.fetch", {31'd0, bus.fetch_en}, 32'h0);
        check("rst.flush", {31'd0, bus.flush}, 32'h0);
        drive(1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1 rst = 1'b1;

        // Sequential run: 0, 4, 8, C.
        idle("seq0");
        idle("seq1");
        idle("seq2");
        #1 check("seq.pc_C", bus.pc, 32'h0000_000C);

        // Wrap boundary at the top of the address space.
        step("to_top", 1'b1, 2'b10, 32'hFFFF_FFFC, 32'h0, 1'b0, 1'b0, 1'b0);
        idle("wrap");
        #1 check("wrap.pc", bus.pc, 32'h0000_0000);

        // Redirect beats a simultaneous stall.
        step("to_10", 1'b1, 2'b10, 32'h10, 32'h0, 1'b0, 1'b0, 1'b0);
        step("br_stall", 1'b1, 2'b10, 32'h40, 32'h0, 1'b1, 1'b0, 1'b0);
        #1 check("br_stall.pc", bus.pc, 32'h40);
        step("stall", 1'b0, 2'b00, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
        step("resume_run", 1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);

        // Misaligned JALR traps; pc and counter hold until resume.
        step("jalr_bad", 1'b1, 2'b01, 32'h0, 32'h0000_0102, 1'b0, 1'b0, 1'b0);
        #1 check("trap.err", {31'd0, bus.misalign_err}, 32'h1);
        step("trap_br", 1'b1, 2'b10, 32'h200, 32'h0, 1'b1, 1'b1, 1'b0);
        step("trap_res", 1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
        idle("post_trap");

        // Halt together with an aligned redirect halts at the target.
        step("halt_br", 1'b1, 2'b10, 32'h80, 32'h0, 1'b0, 1'b1, 1'b0);
        #1 check("halt.pc", bus.pc, 32'h80);
        for (int i = 0; i < 5; i++) begin
            step("halt_ign", 1'b1, 2'b10, $urandom & 32'hFFFF_FFFC, 32'h0, 1'b1, 1'b1, 1'b0);
        end
        step("halt_res", 1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
        idle("post_halt");
        #1 check("halt.pc84", bus.pc, 32'h84);

        // Halt together with a misaligned redirect traps instead.
        step("halt_bad", 1'b1, 2'b01, 32'h0, 32'h0000_0301, 1'b0, 1'b1, 1'b0);
        step("bad_res", 1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
        step("plain_hlt", 1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
        step("hlt_res", 1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);

        // Counter saturation, then asynchronous reset in the middle of a cycle.
        for (int i = 0; i < 17; i++) begin
            step("sat", 1'b1, 2'b10, 32'h1000 + 32'(i) * 32'h8, 32'h0, 1'b0, 1'b0, 1'b0);
        end
        #1 check("sat.cnt", 32'(bus.redirect_cnt), 32'h0000_000F);
        drive(1'b1, 2'b10, 32'h400, 32'h0, 1'b0, 1'b0, 1'b0);
        #2 rst = 1'b0;
        model_reset();
        #1;
        check("arst.pc",    bus.pc, RESET_PC);
        check("arst.cnt",   32'(bus.redirect_cnt), 32'h0);
        check("arst.fetch", {31'd0, bus.fetch_en}, 32'h0);
        check("arst.flush", {31'd0, bus.flush}, 32'h0);
        @(posedge clk);
        #1 rst = 1'b1;
        idle("arst_run");

        // Randomised traffic against the model.
        for (int i = 0; i < 400; i++) begin
            pb  = $urandom;
            alu = $urandom;
            if ($urandom_range(0, 5) != 0) pb  = pb  & 32'hFFFF_FFFC;
            if ($urandom_range(0, 5) != 0) alu = alu & 32'hFFFF_FFFC;
            step("rand", $urandom_range(0, 2) != 0, 2'($urandom), pb, alu,
                 $urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0,
                 $urandom_range(0, 2) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/pc_seq_ctrl.md
PC_SEQ_CTRL -- requirements
Module: pc_seq_ctrl

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, is the PC value loaded on reset; it SHALL be word-aligned.
REQ-002 Parameter CNT_W, default 16, is the width of the redirect counter.
REQ-003 Port clk, input, 1: the single clock; all state SHALL update on its rising edge.
REQ-004 Port rst, input, 1: reset, asynchronous and active-low.
REQ-005 Port ex_valid, input, 1: the EX-stage instruction is valid.
REQ-006 Port branch_f, input, 2: branch decision; 00 = PC+4, 10 = take pc_branch, 01 = take alu_result (JALR), 11 = illegal, treated as 00.
REQ-007 Port pc_branch, input, 32: branch/JAL target.
REQ-008 Port alu_result, input, 32: JALR target.
REQ-009 Port stall, input, 1: load-use hazard; holds the PC.
REQ-010 Port halt_req, input, 1: ECALL/EBREAK seen in ID; requests halt.
REQ-011 Port resume, input, 1: leave HALT or TRAP.
REQ-012 Port pc, output, 32: current fetch address.
REQ-013 Port fetch_en, output, 1: instruction memory read enable.
REQ-014 Port flush, output, 1: kill the IF/ID and ID/EX contents at the next edge.
REQ-015 Port halted, output, 1: the FSM is in HALT.
REQ-016 Port misalign_err, output, 1: the FSM is in TRAP.
REQ-017 Port redirect_cnt, output, CNT_W: count of accepted redirects.

Function
REQ-018 The FSM SHALL have three states: RUN, HALT and TRAP.
REQ-019 redirect SHALL be defined as ex_valid && (branch_f == 10 || branch_f == 01), and is evaluated only in RUN.
REQ-020 target SHALL be pc_branch when branch_f == 10 and alu_result when branch_f == 01.
REQ-021 In RUN, the next-PC priority SHALL be redirect > stall > halt_req > sequential (pc + 4, modulo 2^32, wrapping 32'hFFFF_FFFC to 0).
REQ-022 A redirect with target[1:0] == 00 SHALL load pc <= target at the next edge (one-cycle latency).
REQ-023 A redirect with target[1:0] == 00 SHALL increment redirect_cnt, saturating at all-ones.
REQ-024 A redirect with target[1:0] != 00 SHALL leave pc unchanged, SHALL NOT increment redirect_cnt, and SHALL move the FSM to TRAP.
REQ-025 flush SHALL be combinational and equal to 1 exactly when the FSM is in RUN and redirect is 1, whether the target is aligned or misaligned.
REQ-026 A redirect in the same cycle as stall SHALL win: pc loads the target and flush = 1.
REQ-027 stall without redirect SHALL hold pc with fetch_en = 1.
REQ-028 halt_req in RUN without redirect and without stall SHALL hold pc and move the FSM to HALT.
REQ-029 halt_req together with an aligned redirect SHALL load the target and move the FSM to HALT, so the halt takes effect at the target.
REQ-030 halt_req together with a misaligned redirect SHALL move the FSM to TRAP; TRAP has priority.
REQ-031 In HALT and in TRAP: fetch_en = 0, pc is frozen, and flush = 0.
REQ-032 In HALT and in TRAP, branch_f, stall and halt_req SHALL be ignored.
REQ-033 resume in HALT or TRAP SHALL move the FSM to RUN at the next edge with pc unchanged; fetch restarts at the held pc.
REQ-034 resume in RUN SHALL be ignored.
REQ-035 fetch_en SHALL be 1 in RUN, including during stall.
REQ-036 halted SHALL be 1 exactly when the state is HALT; misalign_err SHALL be 1 exactly when the state is TRAP.

Reset
REQ-037 rst = 0 SHALL immediately, without waiting for clk, force: state RUN, pc = RESET_PC, redirect_cnt = 0.
REQ-038 While rst = 0, fetch_en = 0 and flush = 0, including when rst is asserted mid-redirect or while in HALT or TRAP.
REQ-039 After rst deasserts, the first rising edge SHALL behave as RUN, starting from RESET_PC.

Verification
REQ-040 Sequential wrap: reset, then 3 idle cycles -> pc = 0, 4, 8, C; fetch_en = 1; flush = 0.
REQ-041 Wrap boundary: force pc to FFFF_FFFC with no redirect -> next pc = 0000_0000.
REQ-042 Redirect over stall: at pc = 10, ex_valid = 1, branch_f = 10, pc_branch = 40, stall = 1 -> flush = 1 that cycle; next pc = 40; redirect_cnt = 1.
REQ-043 Misaligned JALR trap: branch_f = 01, alu_result = 0000_0102 -> flush = 1; next state TRAP; misalign_err = 1; pc held; redirect_cnt unchanged; then resume = 1 -> RUN at the same pc.
REQ-044 Halt at target: halt_req = 1 with an aligned redirect to 80 -> pc = 80, halted = 1, fetch_en = 0; 5 cycles of branch_f = 10 leave pc = 80; resume -> pc = 80, then 84.
REQ-045 Saturation and reset: with CNT_W = 4, apply 17 aligned redirects -> redirect_cnt = F; assert rst asynchronously mid-cycle -> pc = RESET_PC and redirect_cnt = 0 before the next edge.
